// File: rtl/npu_input_ctrl.sv
// Host-command sequencer for the NPU input interface: config/data routing, load counting, start/done.
// Optional macro NPU_INPUT_CTRL_TIMEOUT_EN adds a WAIT_CORE watchdog of TIMEOUT_CYCLES.
module npu_input_ctrl #(
   parameter int CNT_W          = 7,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic             CLK,
   input  logic             npu_rst_n,
   input  logic             host_cmd_valid,
   output logic             host_cmd_ready,
   input  logic             host_cmd_is_conf,
   input  logic [32:0]      host_cmd_data,
   output logic             npu_input_interface_conf_data_en,
   output logic [15:0]      npu_input_interface_conf_data,
   output logic             npu_input_fifo_write_en,
   output logic [32:0]      npu_input_data,
   input  logic             npu_input_fifo_full,
   output logic             npu_invoc_start,
   input  logic             npu_invoc_done,
   output logic             ctrl_busy,
   output logic             ctrl_err,
   output logic [CNT_W-1:0] words_loaded
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;

   logic [1:0]       state_q, state_d;
   logic             configured_q, configured_d;
   logic [CNT_W-1:0] num_inputs_q, num_inputs_d;
   logic [CNT_W-1:0] words_q, words_d;
   logic             start_q, start_d;
   logic             err_q, err_d;
   logic             armed_q;
   logic             ready, conf_en, wr_en, data_ok;
   logic [CNT_W-1:0] cfg_num, words_inc;

`ifdef NPU_INPUT_CTRL_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] cnt_q, cnt_d;
`endif

   assign cfg_num   = host_cmd_data[16+CNT_W-1:16];
   assign words_inc = words_q + CNT_W'(1);
   assign data_ok   = configured_q && (num_inputs_q != '0);

   always_comb begin
      state_d      = state_q;
      configured_d = configured_q;
      num_inputs_d = num_inputs_q;
      words_d      = words_q;
      start_d      = 1'b0;
      err_d        = 1'b0;
      ready        = 1'b0;
      conf_en      = 1'b0;
      wr_en        = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (!host_cmd_is_conf && data_ok)
               ready = armed_q & ~npu_input_fifo_full;
            else
               ready = armed_q;
            if (host_cmd_valid && ready) begin
               if (host_cmd_is_conf) begin
                  conf_en      = 1'b1;
                  num_inputs_d = cfg_num;
                  configured_d = 1'b1;
                  words_d      = '0;
                  if (cfg_num != '0) state_d = S_LOAD;
               end else if (data_ok) begin
                  wr_en   = 1'b1;
                  words_d = CNT_W'(1);
                  if (num_inputs_q == CNT_W'(1)) begin
                     state_d = S_WAIT;
                     start_d = 1'b1;
                  end else begin
                     state_d = S_LOAD;
                  end
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_LOAD: begin
            ready = armed_q & ~npu_input_fifo_full;
            if (host_cmd_valid && ready) begin
               if (host_cmd_is_conf) begin
                  err_d = 1'b1;
               end else begin
                  wr_en   = 1'b1;
                  words_d = words_inc;
                  if (words_inc == num_inputs_q) begin
                     state_d = S_WAIT;
                     start_d = 1'b1;
                  end
               end
            end
         end
         S_WAIT: begin
            if (npu_invoc_done) begin
               words_d = '0;
               state_d = S_IDLE;
            end
`ifdef NPU_INPUT_CTRL_TIMEOUT_EN
            else if (cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end
`endif
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef NPU_INPUT_CTRL_TIMEOUT_EN
   // Zero outside WAIT_CORE, so every entry starts the watchdog from 0.
   assign cnt_d = (state_q == S_WAIT) ? cnt_q + TW'(1) : '0;

   always_ff @(posedge CLK or negedge npu_rst_n) begin
      if (!npu_rst_n) cnt_q <= '0;
      else            cnt_q <= cnt_d;
   end
`endif

   always_ff @(posedge CLK or negedge npu_rst_n) begin
      if (!npu_rst_n) begin
         state_q      <= S_IDLE;
         configured_q <= 1'b0;
         num_inputs_q <= '0;
         words_q      <= '0;
         start_q      <= 1'b0;
         err_q        <= 1'b0;
         armed_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         configured_q <= configured_d;
         num_inputs_q <= num_inputs_d;
         words_q      <= words_d;
         start_q      <= start_d;
         err_q        <= err_d;
         armed_q      <= 1'b1;
      end
   end

   assign host_cmd_ready                   = ready;
   assign npu_input_interface_conf_data_en = conf_en;
   assign npu_input_interface_conf_data    = host_cmd_data[15:0];
   assign npu_input_fifo_write_en          = wr_en;
   assign npu_input_data                   = host_cmd_data;
   assign npu_invoc_start                  = start_q;
   assign ctrl_err                         = err_q;
   assign ctrl_busy                        = (state_q != S_IDLE);
   assign words_loaded                     = words_q;

endmodule
